// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported variable-latency memory between fetch and data stages
module mem_port_arbiter #(
  parameter int MAX_DATA_RUN = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_busy,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_wstrb,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        dm_busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        timeout
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ = 2'd1;
  localparam logic [1:0] WAIT_DATA = 2'd2;
  localparam int CW = $clog2(MAX_DATA_RUN + 1);
  logic [1:0] state;
  logic owner;
  logic drop;
  logic done;
  logic [CW-1:0] run;
  logic [31:0] tcnt;
  logic run_full, grant_f, grant_d, to_hit, finish;
  // done blocks a new grant in the cycle the completion pulse is visible
  always_comb begin
    run_full = run == CW'(MAX_DATA_RUN);
    grant_f = state == IDLE && !done && if_req && !if_flush && (!dm_req || run_full);
    grant_d = state == IDLE && !done && dm_req && !grant_f;
    to_hit = TIMEOUT != 0 && tcnt == 32'(TIMEOUT - 1);
    finish = state == WAIT_DATA && (mem_rvalid || to_hit);
  end
  assign if_busy = if_req & ~if_valid;
  assign dm_busy = dm_req & ~dm_valid;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= 1'b0;
      drop <= 1'b0;
      done <= 1'b0;
      run <= '0;
      tcnt <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      if_rdata <= '0;
      if_valid <= 1'b0;
      dm_rdata <= '0;
      dm_valid <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      timeout <= 1'b0;
      done <= 1'b0;
      if (grant_d || grant_f) begin
        state <= REQ;
        mem_req <= 1'b1;
        owner <= grant_d;
        mem_we <= grant_d & dm_we;
        mem_addr <= grant_d ? dm_addr : if_addr;
        mem_wdata <= grant_d ? dm_wdata : '0;
        mem_wstrb <= grant_d && dm_we ? dm_wstrb : 4'b0000;
        run <= grant_d && if_req ? (run_full ? run : run + 1'b1) : '0;
      end
      if (state != IDLE && !owner && if_flush) drop <= 1'b1;
      if (state == REQ && mem_ready) begin
        state <= WAIT_DATA;
        mem_req <= 1'b0;
        tcnt <= '0;
      end
      if (state == WAIT_DATA) tcnt <= tcnt + 1;
      if (finish) begin
        state <= IDLE;
        done <= 1'b1;
        drop <= 1'b0;
        timeout <= ~mem_rvalid;
        if (owner) begin
          dm_valid <= 1'b1;
          dm_rdata <= mem_rvalid ? mem_rdata : '0;
        end else if (!drop && !if_flush) begin
          if_valid <= 1'b1;
          if_rdata <= mem_rvalid ? mem_rdata : '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, latency, flush, timeout and reset
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic if_req, if_flush, if_valid, if_busy;
  logic [31:0] if_addr, if_rdata;
  logic dm_req, dm_we, dm_valid, dm_busy;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0] dm_wstrb, mem_wstrb;
  logic mem_req, mem_we, mem_ready, mem_rvalid, timeout;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic ready_en, rv_en;
  int rv_delay;
  int mcnt = 0;
  logic [31:0] paddr = '0;
  logic [31:0] acc_addr[$], acc_wdata[$];
  logic acc_we[$];
  logic [3:0] acc_strb[$];
  int ifv_n = 0, dmv_n = 0, to_n = 0;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.MAX_DATA_RUN(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_busy(if_busy),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_busy(dm_busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .timeout(timeout)
  );
  // memory responds rv_delay cycles after accepting; 0x100 holds a known instruction
  assign mem_ready = mem_req & ready_en;
  assign mem_rvalid = rv_en && mcnt == 1;
  assign mem_rdata = paddr == 32'h100 ? 32'h00500093 : ~paddr;
  always @(posedge clk) begin
    if (reset) mcnt <= 0;
    else if (mem_req && mem_ready) begin
      mcnt <= rv_delay;
      paddr <= mem_addr;
    end else if (mcnt != 0) mcnt <= mcnt - 1;
  end
  always @(posedge clk) begin
    if (!reset) begin
      if (mem_req && mem_ready) begin
        acc_addr.push_back(mem_addr);
        acc_wdata.push_back(mem_wdata);
        acc_we.push_back(mem_we);
        acc_strb.push_back(mem_wstrb);
      end
      if (if_valid) ifv_n++;
      if (dm_valid) dmv_n++;
      if (timeout) to_n++;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_valid(input bit data, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!(data ? dm_valid : if_valid) && lat < 50);
    if (!(data ? dm_valid : if_valid)) lat = 999;
  endtask
  task automatic clear_log();
    acc_addr.delete();
    acc_wdata.delete();
    acc_we.delete();
    acc_strb.delete();
  endtask
  initial begin
    int lat, n, t, dcount;
    logic [31:0] ord[7];
    reset = 1'b1;
    {if_req, if_flush, dm_req, dm_we} = '0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
    ready_en = 1'b1; rv_en = 1'b1; rv_delay = 1;
    repeat (3) tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_dm_valid", dm_valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_if_busy", if_busy, 0);
    reset = 1'b0;
    tick();
    if_addr = 32'h100; if_req = 1'b1;
    #1 chk("f_busy_t0", if_busy, 1);
    tick();
    chk("f_busy_t1", if_busy, 1);
    chk("f_mem_req", mem_req, 1);
    tick();
    chk("f_busy_t2", if_busy, 1);
    chk("f_valid_early", if_valid, 0);
    tick();
    chk("f_valid_t3", if_valid, 1);
    chk("f_rdata", if_rdata, 32'h00500093);
    chk("f_busy_t3", if_busy, 0);
    if_req = 1'b0;
    tick();
    clear_log();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'hDEADBEEF; dm_wstrb = 4'b0011;
    if_req = 1'b1; if_addr = 32'h140;
    wait_valid(1, lat);
    chk("pri_dm_lat", lat, 3);
    dm_req = 1'b0;
    wait_valid(0, lat);
    chk("pri_if_lat", lat, 4);
    chk("pri_if_rdata", if_rdata, 32'hFFFFFEBF);
    if_req = 1'b0;
    chk("pri_n_acc", acc_addr.size(), 2);
    chk("pri_addr0", acc_addr[0], 32'h2000);
    chk("pri_we0", acc_we[0], 1);
    chk("pri_strb0", acc_strb[0], 4'b0011);
    chk("pri_wdata0", acc_wdata[0], 32'hDEADBEEF);
    chk("pri_addr1", acc_addr[1], 32'h140);
    chk("pri_we1", acc_we[1], 0);
    chk("pri_strb1", acc_strb[1], 4'b0000);
    tick();
    rv_delay = 12;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000;
    wait_valid(1, lat);
    chk("to_lat", lat, 10);
    chk("to_pulse", timeout, 1);
    chk("to_rdata", dm_rdata, 0);
    dm_req = 1'b0;
    tick();
    n = dmv_n; t = to_n;
    repeat (8) tick();
    chk("to_late_dmv", dmv_n, n);
    chk("to_late_to", to_n, t);
    chk("to_idle", mem_req, 0);
    rv_delay = 3;
    if_addr = 32'h180; if_req = 1'b1;
    tick();
    tick();
    if_flush = 1'b1; if_req = 1'b0;
    tick();
    if_flush = 1'b0;
    n = ifv_n;
    repeat (6) tick();
    chk("fl_no_valid", ifv_n, n);
    chk("fl_idle", mem_req, 0);
    rv_delay = 1;
    if_addr = 32'h200; if_req = 1'b1;
    wait_valid(0, lat);
    chk("fl_next_lat", lat, 3);
    chk("fl_next_rdata", if_rdata, 32'hFFFFFDFF);
    if_req = 1'b0;
    tick();
    ready_en = 1'b0;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h5000;
    tick();
    tick();
    chk("rr_in_req", mem_req, 1);
    reset = 1'b1; dm_req = 1'b0;
    tick();
    chk("rr_mem_req", mem_req, 0);
    reset = 1'b0; ready_en = 1'b1;
    n = ifv_n + dmv_n;
    repeat (5) tick();
    chk("rr_no_valid", ifv_n + dmv_n, n);
    chk("rr_idle", mem_req, 0);
    clear_log();
    dm_addr = 32'h4000; dm_we = 1'b0; if_addr = 32'h300;
    dm_req = 1'b1; if_req = 1'b1;
    dcount = 0;
    for (int k = 0; k < 200 && dcount < 6; k++) begin
      tick();
      if (dm_valid) dcount++;
    end
    chk("run_dcount", dcount, 6);
    dm_req = 1'b0; if_req = 1'b0;
    repeat (6) tick();
    ord = '{32'h4000, 32'h4000, 32'h4000, 32'h4000, 32'h300, 32'h4000, 32'h4000};
    for (int i = 0; i < 7; i++) chk($sformatf("run_order%0d", i), acc_addr[i], ord[i]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
